wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single GPR write-back port between three result producers: the
//  fixed-latency ALU path, the load/store unit and the multi-cycle unit
//  (mul/div/SPR moves). The ALU always wins; load/store and multi-cycle
//  round-robin. A starvation counter raises an EX stall so the ALU slot frees.
//  Sits between EX/MEM result sources and the register file write port.
// PARAMETERS
//  DATA_W        32  width of result data (Word)
//  ADDR_W        5   GPR index width
//  STARVE_LIMIT  4   wait cycles (>=1) before a requester forces stall_ex
// PORTS
//  clk        in   1       clock, all logic on posedge
//  resetb     in   1       synchronous reset, active low
//  alu_we     in   1       ALU result valid this cycle (no back-pressure)
//  alu_addr   in   ADDR_W  ALU destination GPR
//  alu_data   in   DATA_W  ALU result
//  ls_valid   in   1       load result pending
//  ls_ready   out  1       load result accepted this cycle
//  ls_addr    in   ADDR_W  load destination GPR
//  ls_data    in   DATA_W  load data
//  mc_valid   in   1       multi-cycle result pending
//  mc_ready   out  1       multi-cycle result accepted this cycle
//  mc_addr    in   ADDR_W  multi-cycle destination GPR
//  mc_data    in   DATA_W  multi-cycle result
//  gpr_we     out  1       register file write enable (registered)
//  gpr_addr   out  ADDR_W  register file write index (registered)
//  gpr_data   out  DATA_W  register file write data (registered)
//  stall_ex   out  1       request: no ALU write next cycle (registered)
// BEHAVIOUR
//  - Reset (resetb=0 at posedge): gpr_we=0, gpr_addr=0, gpr_data=0, stall_ex=0,
//    ls_ready=mc_ready=0, rr pointer=LS, wait counters=0, skid empty.
//  - Handshake: valid held with stable addr/data until ready; transfer on
//    valid&&ready. ready never asserted while resetb=0.
//  - Grant per cycle, in order: alu_we; else requester with wait==STARVE_LIMIT
//    (LS before MC if both); else rr pointer side if valid; else other side.
//  - rr pointer flips to the loser after every LS or MC grant; unchanged on
//    ALU grants or idle cycles.
//  - Winner's addr/data registered to gpr_*; gpr_we=1 the cycle after grant;
//    1-cycle latency. No grant -> gpr_we=0, gpr_addr/gpr_data hold.
//  - Wait counter per LS/MC: +1 each cycle valid && !ready, saturates at
//    STARVE_LIMIT, cleared on grant or when valid low.
//  - stall_ex=1 for exactly one cycle after a counter first reaches the limit;
//    re-armed only after that counter clears. In the stall_ex cycle the
//    pipeline keeps alu_we=0; if alu_we=1 anyway the ALU still wins (SVA
//    assertion flags the violation, no data is lost).
//  - Same destination from LS and MC together: both written, in grant order;
//    no merging or hazard check here.
//  - Reset mid-transfer: pending requests dropped, no write after reset
//    release until a fresh handshake.
// CONFIGURATION
//  WB_LS_SKID_EN defined: 1-entry skid register on LS; ls_ready=!skid_full
//    (registered, independent of ls_valid); skid entry, not raw LS, competes
//    in arbitration; LS accept->gpr_we latency >=2; counter tracks skid entry.
//  Not defined: ls_ready is the combinational LS grant; latency 1 cycle.
// TESTING
//  1 resetb=0 3 cycles, all valids/alu_we=1 -> gpr_we=0, readies=0, stall_ex=0
//  2 alu_we=1 addr=3 data=0xDEADBEEF, ls_valid=1 -> next cycle gpr_we=1
//    addr=3 data=0xDEADBEEF; ls_ready=0 that cycle
//  3 ALU idle, ls/mc valid continuously (ls addr 1, mc addr 2) -> gpr_addr
//    sequence 1,2,1,2; ready pulses alternate
//  4 alu_we held 1, ls_valid=1, STARVE_LIMIT=4 -> stall_ex=1 one cycle after
//    4th wait cycle; bench drops alu_we -> LS granted, gpr_data=ls_data
//  5 ls_valid pending under ALU traffic, resetb=0 one cycle then 1, ls_valid=0
//    -> no gpr_we ever for the dropped load, counters restart at 0
//  6 WB_LS_SKID_EN, alu_we=1 busy, ls_valid 2 cycles -> ls_ready=1 then 0;
//    after alu_we=0, gpr_we=1 with first load data, ls_ready returns to 1

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: GPR write-back port sharing for ALU, load/store and multi-cycle results.
// Optional build macro WB_LS_SKID_EN adds a 1-entry skid register on the load/store input.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              alu_we,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ls_valid,
  output logic              ls_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0] mc_data,
  output logic              gpr_we,
  output logic [ADDR_W-1:0] gpr_addr,
  output logic [DATA_W-1:0] gpr_data,
  output logic              stall_ex
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    G_NONE,
    G_ALU,
    G_LS,
    G_MC
  } gnt_e;

  typedef enum logic {
    RR_LS,
    RR_MC
  } rr_e;

  gnt_e gnt;
  rr_e  rr_q, rr_d;

  logic [CW-1:0] ls_wait_q, ls_wait_d;
  logic [CW-1:0] mc_wait_q, mc_wait_d;
  logic          stall_d;

  logic              ls_src_v;
  logic [ADDR_W-1:0] ls_src_a;
  logic [DATA_W-1:0] ls_src_d;

`ifdef WB_LS_SKID_EN
  logic              skid_full, skid_full_d;
  logic              ls_rdy_q;
  logic [ADDR_W-1:0] skid_a;
  logic [DATA_W-1:0] skid_d;

  assign ls_src_v = skid_full;
  assign ls_src_a = skid_a;
  assign ls_src_d = skid_d;
  assign ls_ready = ls_rdy_q & resetb;

  // Skid occupancy: drain on grant, fill on accept
  always_comb begin
    skid_full_d = skid_full;
    if (gnt == G_LS)
      skid_full_d = 1'b0;
    else if (ls_valid && ls_ready)
      skid_full_d = 1'b1;
  end

  // Skid entry and registered ready
  always_ff @(posedge clk) begin
    if (!resetb) begin
      skid_full <= 1'b0;
      ls_rdy_q  <= 1'b0;
      skid_a    <= '0;
      skid_d    <= '0;
    end else begin
      skid_full <= skid_full_d;
      ls_rdy_q  <= !skid_full_d;
      if (ls_valid && ls_ready) begin
        skid_a <= ls_addr;
        skid_d <= ls_data;
      end
    end
  end
`else
  assign ls_src_v = ls_valid;
  assign ls_src_a = ls_addr;
  assign ls_src_d = ls_data;
  assign ls_ready = (gnt == G_LS);
`endif

  assign mc_ready = (gnt == G_MC);

  // Grant: ALU, then starved side, then rr side, then other side
  always_comb begin
    gnt = G_NONE;
    if (!resetb)
      gnt = G_NONE;
    else if (alu_we)
      gnt = G_ALU;
    else if (ls_src_v && ls_wait_q == LIM)
      gnt = G_LS;
    else if (mc_valid && mc_wait_q == LIM)
      gnt = G_MC;
    else if (rr_q == RR_LS)
      gnt = ls_src_v ? G_LS : (mc_valid ? G_MC : G_NONE);
    else
      gnt = mc_valid ? G_MC : (ls_src_v ? G_LS : G_NONE);
  end

  // Next rr pointer, wait counters and stall request
  always_comb begin
    rr_d = rr_q;
    if (gnt == G_LS)
      rr_d = RR_MC;
    else if (gnt == G_MC)
      rr_d = RR_LS;

    ls_wait_d = ls_wait_q;
    if (!ls_src_v || gnt == G_LS)
      ls_wait_d = '0;
    else if (ls_wait_q != LIM)
      ls_wait_d = ls_wait_q + 1'b1;

    mc_wait_d = mc_wait_q;
    if (!mc_valid || gnt == G_MC)
      mc_wait_d = '0;
    else if (mc_wait_q != LIM)
      mc_wait_d = mc_wait_q + 1'b1;

    stall_d = (ls_wait_d == LIM && ls_wait_q != LIM) ||
              (mc_wait_d == LIM && mc_wait_q != LIM);
  end

  // Arbiter state and registered write-back port
  always_ff @(posedge clk) begin
    if (!resetb) begin
      rr_q      <= RR_LS;
      ls_wait_q <= '0;
      mc_wait_q <= '0;
      stall_ex  <= 1'b0;
      gpr_we    <= 1'b0;
      gpr_addr  <= '0;
      gpr_data  <= '0;
    end else begin
      rr_q      <= rr_d;
      ls_wait_q <= ls_wait_d;
      mc_wait_q <= mc_wait_d;
      stall_ex  <= stall_d;
      gpr_we    <= (gnt != G_NONE);
      unique case (gnt)
        G_ALU: begin
          gpr_addr <= alu_addr;
          gpr_data <= alu_data;
        end
        G_LS: begin
          gpr_addr <= ls_src_a;
          gpr_data <= ls_src_d;
        end
        G_MC: begin
          gpr_addr <= mc_addr;
          gpr_data <= mc_data;
        end
        default: ;
      endcase
    end
  end

  a_no_alu_in_stall: assert property (
    @(posedge clk) disable iff (!resetb) stall_ex |-> !alu_we
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: randomized check of wb_port_arbiter against a reference model.
// Build with WB_LS_SKID_EN defined to run the skid-register sequence instead.
module tb_wb_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        resetb;
  logic        alu_we;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ls_valid, ls_ready;
  logic [4:0]  ls_addr;
  logic [31:0] ls_data;
  logic        mc_valid, mc_ready;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        gpr_we;
  logic [4:0]  gpr_addr;
  logic [31:0] gpr_data;
  logic        stall_ex;

  int checks = 0;
  int failures = 0;

  wb_port_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .alu_we(alu_we),
    .alu_addr(alu_addr),
    .alu_data(alu_data),
    .ls_valid(ls_valid),
    .ls_ready(ls_ready),
    .ls_addr(ls_addr),
    .ls_data(ls_data),
    .mc_valid(mc_valid),
    .mc_ready(mc_ready),
    .mc_addr(mc_addr),
    .mc_data(mc_data),
    .gpr_we(gpr_we),
    .gpr_addr(gpr_addr),
    .gpr_data(gpr_data),
    .stall_ex(stall_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 none, 1 alu, 2 ls, 3 mc
  int          m_next = 0;
  int          m_lsw = 0;
  int          m_mcw = 0;
  int          m_gnt = 0;
  bit          m_stall = 0;
  bit          e_we = 0;
  logic [4:0]  e_addr = '0;
  logic [31:0] e_data = '0;

  task automatic step(input bit rb, input bit aw, input logic [4:0] aa,
                      input logic [31:0] ad, input bit lv,
                      input logic [4:0] la, input logic [31:0] ld,
                      input bit mv, input logic [4:0] ma,
                      input logic [31:0] md);
    int g, nl, nm;
    resetb = rb; alu_we = aw; alu_addr = aa; alu_data = ad;
    ls_valid = lv; ls_addr = la; ls_data = ld;
    mc_valid = mv; mc_addr = ma; mc_data = md;
    #1;
    if (!rb) g = 0;
    else if (aw) g = 1;
    else if (lv && m_lsw == LIM) g = 2;
    else if (mv && m_mcw == LIM) g = 3;
    else if (m_next == 2) g = lv ? 2 : (mv ? 3 : 0);
    else g = mv ? 3 : (lv ? 2 : 0);
    chk("ls_ready", 64'(ls_ready), 64'(g == 2));
    chk("mc_ready", 64'(mc_ready), 64'(g == 3));
    @(posedge clk);
    if (!rb) begin
      m_next = 2; m_lsw = 0; m_mcw = 0; m_stall = 0;
      e_we = 0; e_addr = '0; e_data = '0;
    end else begin
      nl = (!lv || g == 2) ? 0 : ((m_lsw + 1 > LIM) ? LIM : m_lsw + 1);
      nm = (!mv || g == 3) ? 0 : ((m_mcw + 1 > LIM) ? LIM : m_mcw + 1);
      m_stall = (nl == LIM && m_lsw < LIM) || (nm == LIM && m_mcw < LIM);
      m_lsw = nl;
      m_mcw = nm;
      e_we = (g != 0);
      if (g == 1) begin e_addr = aa; e_data = ad; end
      if (g == 2) begin e_addr = la; e_data = ld; m_next = 3; end
      if (g == 3) begin e_addr = ma; e_data = md; m_next = 2; end
    end
    m_gnt = g;
    #1;
    chk("gpr_we", 64'(gpr_we), 64'(e_we));
    chk("gpr_addr", 64'(gpr_addr), 64'(e_addr));
    chk("gpr_data", 64'(gpr_data), 64'(e_data));
    chk("stall_ex", 64'(stall_ex), 64'(m_stall));
    @(negedge clk);
  endtask

`ifndef WB_LS_SKID_EN
  initial begin
    bit          lv, mv, aw, rb;
    logic [4:0]  la, ma;
    logic [31:0] ld, md;
    int          n;
    resetb = 0; alu_we = 0; alu_addr = 0; alu_data = 0;
    ls_valid = 0; ls_addr = 0; ls_data = 0;
    mc_valid = 0; mc_addr = 0; mc_data = 0;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      step(0, 1, 5'd9, 32'h99, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22);

    step(1, 1, 5'd3, 32'hDEADBEEF, 1, 5'd5, 32'h5555, 0, 5'd0, 32'h0);
    step(1, 0, 5'd0, 32'h0, 1, 5'd5, 32'h5555, 0, 5'd0, 32'h0);

    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 5'd0, 32'h0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);

    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    n = 0;
    do begin
      n++;
      step(1, !m_stall, 5'd7, 32'h70 + n, 1, 5'd4, 32'hC0FFEE, 0, 5'd0, 0);
    end while (m_gnt != 2 && n < 12);
    chk("starve_cycles", 64'(n), 64'(LIM + 1));

    for (int i = 0; i < 3; i++)
      step(1, 1, 5'd8, 32'h80, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0);
    step(0, 1, 5'd8, 32'h80, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 5'd0, 32'h0, 0, 5'd6, 32'h66, 0, 5'd0, 32'h0);

    lv = 0; mv = 0; la = 0; ma = 0; ld = 0; md = 0;
    for (int i = 0; i < 3000; i++) begin
      rb = ($urandom_range(0, 60) != 0);
      aw = ($urandom_range(0, 9) < 6) && !m_stall;
      if (!lv && $urandom_range(0, 2) != 0) begin
        lv = 1; la = 5'($urandom_range(0, 3)); ld = $urandom;
      end
      if (!mv && $urandom_range(0, 2) != 0) begin
        mv = 1; ma = 5'($urandom_range(0, 3)); md = $urandom;
      end
      step(rb, aw, 5'($urandom), $urandom, lv, la, ld, mv, ma, md);
      if (!rb) begin lv = 0; mv = 0; end
      if (m_gnt == 2) lv = 0;
      if (m_gnt == 3) mv = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
`else
  initial begin
    resetb = 0; alu_we = 1; alu_addr = 5'd3; alu_data = 32'hA0;
    ls_valid = 1; ls_addr = 5'd7; ls_data = 32'h11;
    mc_valid = 0; mc_addr = 0; mc_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ls_ready", 64'(ls_ready), 64'd0);
    chk("rst_gpr_we", 64'(gpr_we), 64'd0);
    resetb = 1; ls_valid = 0; alu_we = 0;
    @(negedge clk);
    chk("idle_ls_ready", 64'(ls_ready), 64'd1);
    chk("idle_gpr_we", 64'(gpr_we), 64'd0);
    alu_we = 1; ls_valid = 1; ls_data = 32'h11;
    #1 chk("acc_ls_ready", 64'(ls_ready), 64'd1);
    @(negedge clk);
    chk("alu_we_1", 64'(gpr_we), 64'd1);
    chk("alu_data_1", 64'(gpr_data), 64'hA0);
    ls_data = 32'h22;
    #1 chk("full_ls_ready", 64'(ls_ready), 64'd0);
    @(negedge clk);
    chk("alu_data_2", 64'(gpr_data), 64'hA0);
    chk("hold_ls_ready", 64'(ls_ready), 64'd0);
    alu_we = 0; ls_valid = 0;
    @(negedge clk);
    chk("skid_gpr_we", 64'(gpr_we), 64'd1);
    chk("skid_gpr_addr", 64'(gpr_addr), 64'd7);
    chk("skid_gpr_data", 64'(gpr_data), 64'h11);
    chk("skid_ls_ready", 64'(ls_ready), 64'd1);
    @(negedge clk);
    chk("after_gpr_we", 64'(gpr_we), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
`endif

endmodule
